// File: rtl/proc_io_pkg.sv
// Shared widths, slot state encoding and packed-lane helper for the processor I/O scheduler.
package proc_io_pkg;

  localparam int unsigned NUIOIN = 4;
  localparam int unsigned NUIOOU = 4;
  localparam int unsigned NBIN   = 19;
  localparam int unsigned NBOUT  = 28;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Base bit index of lane k in a bus of packed width-bit lanes.
  function automatic int unsigned lane(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/io_in_slot.sv
// Single-entry input holding register: full flag, registered ready and sticky underrun.
module io_in_slot
  import proc_io_pkg::*;
#(
  parameter int unsigned W = NBIN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] src_data,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic         take,
  input  logic         clr_err,
  output logic [W-1:0] data,
  output logic         underrun
);

  slot_state_e state, state_next;
  logic        load_c;
  logic        underrun_set_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SLOT_EMPTY;
    else     state <= state_next;
  end

  // A read of an empty slot flags underrun; a source handshake still loads the sample.
  always_comb begin
    state_next     = state;
    load_c         = 1'b0;
    underrun_set_c = 1'b0;
    case (state)
      SLOT_EMPTY: begin
        if (take) underrun_set_c = 1'b1;
        if (src_valid && src_ready) begin
          load_c     = 1'b1;
          state_next = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (take) state_next = SLOT_EMPTY;
      end
      default: state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      src_ready <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (load_c) data <= src_data;
      src_ready <= (state_next != SLOT_FULL);
      underrun  <= underrun_set_c | (underrun & ~clr_err);
    end
  end

endmodule

// File: rtl/proc_io_ctrl.sv
// I/O scheduler between the float processor and streaming sources/sinks, with frame tracking.
module proc_io_ctrl
  import proc_io_pkg::*;
#(
  parameter int unsigned NUIOIN = proc_io_pkg::NUIOIN,
  parameter int unsigned NUIOOU = proc_io_pkg::NUIOOU,
  parameter int unsigned NBIN   = proc_io_pkg::NBIN,
  parameter int unsigned NBOUT  = proc_io_pkg::NBOUT,
  parameter logic [NUIOOU-1:0] OUT_MASK = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUIOIN*NBIN-1:0]    src_data,
  input  logic [NUIOIN-1:0]         src_valid,
  output logic [NUIOIN-1:0]         src_ready,
  input  logic [NUIOIN-1:0]         req_in,
  output logic [NBIN-1:0]           io_in,
  input  logic [NBOUT-1:0]          io_out,
  input  logic [NUIOOU-1:0]         out_en,
  output logic [NUIOOU*NBOUT-1:0]   snk_data,
  output logic [NUIOOU-1:0]         snk_valid,
  input  logic [NUIOOU-1:0]         snk_ready,
  output logic [NUIOIN-1:0]         underrun,
  output logic [NUIOOU-1:0]         overrun,
  input  logic                      clr_err,
  output logic                      frame
);

  logic [NUIOIN-1:0] req_sel_c;
  logic [NBIN-1:0]   slot_data [NUIOIN];
  logic [NUIOOU-1:0] ovr_evt_c;
  logic [NUIOOU-1:0] written, written_next_c;
  logic              frame_hit_c;

  // Only the lowest-index read strobe is honoured.
  assign req_sel_c = req_in & (~req_in + NUIOIN'(1));

  for (genvar k = 0; k < NUIOIN; k++) begin : g_slot
    io_in_slot #(.W(NBIN)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .src_data  (src_data[lane(k, NBIN) +: NBIN]),
      .src_valid (src_valid[k]),
      .src_ready (src_ready[k]),
      .take      (req_sel_c[k]),
      .clr_err   (clr_err),
      .data      (slot_data[k]),
      .underrun  (underrun[k])
    );
  end

  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (req_sel_c[k]) io_in = slot_data[k];
    end
  end

  assign ovr_evt_c      = out_en & snk_valid & ~snk_ready;
  assign written_next_c = written | out_en;
  assign frame_hit_c    = ((written_next_c & OUT_MASK) == OUT_MASK);

  // Output registers: a write always captures; newest data wins over an unread word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snk_data  <= '0;
      snk_valid <= '0;
      overrun   <= '0;
      written   <= '0;
      frame     <= 1'b0;
    end else begin
      for (int k = 0; k < NUIOOU; k++) begin
        if (out_en[k]) begin
          snk_data[lane(k, NBOUT) +: NBOUT] <= io_out;
          snk_valid[k]                      <= 1'b1;
        end else if (snk_ready[k]) begin
          snk_valid[k] <= 1'b0;
        end
      end
      overrun <= ovr_evt_c | (overrun & ~{NUIOOU{clr_err}});
      frame   <= frame_hit_c;
      written <= frame_hit_c ? '0 : written_next_c;
    end
  end

endmodule

// File: tb/tb_proc_io_ctrl.sv
// Directed self-checking bench for proc_io_ctrl.
module tb_proc_io_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic [75:0]   src_data;
  logic [3:0]    src_valid;
  logic [3:0]    src_ready;
  logic [3:0]    req_in;
  logic [18:0]   io_in;
  logic [27:0]   io_out;
  logic [3:0]    out_en;
  logic [111:0]  snk_data;
  logic [3:0]    snk_valid;
  logic [3:0]    snk_ready;
  logic [3:0]    underrun;
  logic [3:0]    overrun;
  logic          clr_err;
  logic          frame;

  int tests = 0;
  int fails = 0;

  proc_io_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .req_in    (req_in),
    .io_in     (io_in),
    .io_out    (io_out),
    .out_en    (out_en),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .underrun  (underrun),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_data  = '0;
    src_valid = '0;
    req_in    = '0;
    io_out    = '0;
    out_en    = '0;
    snk_ready = '0;
    clr_err   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (src_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_src_ready: got %b want 0000", src_ready);
    end
    tests++;
    if ({snk_valid, underrun, overrun, frame} !== 13'b0 || snk_data !== 112'b0) begin
      fails++; $display("FAIL reset_outputs: snk_valid=%b underrun=%b overrun=%b frame=%b snk_data=%h want all 0",
                        snk_valid, underrun, overrun, frame, snk_data);
    end
  endtask

  task automatic test_load_consume();
    do_reset();
    src_valid[2]       = 1'b1;
    src_data[38 +: 19] = 19'h12345;
    step();
    tests++;
    if (src_ready[2] !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b want 1", src_ready[2]);
    end
    step();
    src_valid = '0;
    tests++;
    if (src_ready[2] !== 1'b0) begin
      fails++; $display("FAIL ready_after_load: got %b want 0", src_ready[2]);
    end
    tests++;
    if (io_in !== 19'h0) begin
      fails++; $display("FAIL io_in_idle: got %h want 0", io_in);
    end
    req_in = 4'b0100;
    #1;
    tests++;
    if (io_in !== 19'h12345) begin
      fails++; $display("FAIL io_in_slot2: got %h want 12345", io_in);
    end
    step();
    req_in = '0;
    tests++;
    if (src_ready[2] !== 1'b1 || underrun !== 4'b0000) begin
      fails++; $display("FAIL consume_slot2: ready=%b underrun=%b want 1 0000", src_ready[2], underrun);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    req_in = 4'b0001;
    #1;
    tests++;
    if (io_in !== 19'h0) begin
      fails++; $display("FAIL io_in_empty: got %h want 0", io_in);
    end
    step();
    req_in = '0;
    tests++;
    if (underrun !== 4'b0001) begin
      fails++; $display("FAIL underrun_set: got %b want 0001", underrun);
    end
    step();
    tests++;
    if (underrun !== 4'b0001) begin
      fails++; $display("FAIL underrun_sticky: got %b want 0001", underrun);
    end
    clr_err = 1'b1;
    step();
    tests++;
    if (underrun !== 4'b0000) begin
      fails++; $display("FAIL underrun_clear: got %b want 0000", underrun);
    end
    req_in = 4'b0001;
    step();
    clr_err = 1'b0;
    req_in  = '0;
    tests++;
    if (underrun !== 4'b0001) begin
      fails++; $display("FAIL underrun_clr_collision: got %b want 0001", underrun);
    end
  endtask

  task automatic test_multihot();
    do_reset();
    src_valid          = 4'b0110;
    src_data[19 +: 19] = 19'h0AAAA;
    src_data[38 +: 19] = 19'h05555;
    step();
    step();
    src_valid = '0;
    req_in    = 4'b0110;
    #1;
    tests++;
    if (io_in !== 19'h0AAAA) begin
      fails++; $display("FAIL multihot_io_in: got %h want 0aaaa", io_in);
    end
    step();
    req_in = '0;
    tests++;
    if (src_ready[2:1] !== 2'b01 || underrun !== 4'b0000) begin
      fails++; $display("FAIL multihot_state: ready[2:1]=%b underrun=%b want 01 0000", src_ready[2:1], underrun);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    out_en = 4'b1000;
    io_out = 28'h0ABCDEF;
    step();
    out_en = '0;
    tests++;
    if (snk_valid !== 4'b1000 || snk_data[84 +: 28] !== 28'h0ABCDEF || overrun !== 4'b0000) begin
      fails++; $display("FAIL sink3_write: valid=%b data=%h overrun=%b want 1000 0abcdef 0000",
                        snk_valid, snk_data[84 +: 28], overrun);
    end
    out_en = 4'b1000;
    io_out = 28'h1;
    step();
    out_en = '0;
    tests++;
    if (snk_data[84 +: 28] !== 28'h1 || overrun !== 4'b1000 || snk_valid[3] !== 1'b1) begin
      fails++; $display("FAIL sink3_overrun: data=%h overrun=%b valid=%b want 0000001 1000 1",
                        snk_data[84 +: 28], overrun, snk_valid[3]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_en = 4'b0010;
    io_out = 28'h55;
    step();
    out_en    = 4'b0010;
    io_out    = 28'h66;
    snk_ready = 4'b0010;
    step();
    out_en = '0;
    tests++;
    if (snk_valid[1] !== 1'b1 || snk_data[28 +: 28] !== 28'h66 || overrun !== 4'b0000) begin
      fails++; $display("FAIL sink1_handoff: valid=%b data=%h overrun=%b want 1 0000066 0000",
                        snk_valid[1], snk_data[28 +: 28], overrun);
    end
    step();
    snk_ready = '0;
    tests++;
    if (snk_valid[1] !== 1'b0) begin
      fails++; $display("FAIL sink1_drain: got %b want 0", snk_valid[1]);
    end
  endtask

  task automatic test_frame();
    logic [3:0] seq_a [4];
    logic [3:0] seq_b [5];
    int pulses;
    seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq_b = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      out_en = seq_a[i];
      step();
      if (frame === 1'b1) pulses++;
      tests++;
      if (frame !== (i == 3)) begin
        fails++; $display("FAIL frame_a_step%0d: got %b want %b", i, frame, (i == 3));
      end
    end
    out_en = '0;
    step();
    if (frame === 1'b1) pulses++;
    for (int i = 0; i < 5; i++) begin
      out_en = seq_b[i];
      step();
      if (frame === 1'b1) pulses++;
      tests++;
      if (frame !== (i == 4)) begin
        fails++; $display("FAIL frame_b_step%0d: got %b want %b", i, frame, (i == 4));
      end
    end
    out_en = '0;
    step();
    if (frame === 1'b1) pulses++;
    tests++;
    if (pulses != 2) begin
      fails++; $display("FAIL frame_pulse_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    src_valid          = 4'b0010;
    src_data[19 +: 19] = 19'h2AAAA;
    step();
    step();
    src_valid = '0;
    out_en    = 4'b0001;
    io_out    = 28'h777;
    step();
    out_en = '0;
    req_in = 4'b0010;
    #1;
    tests++;
    if (src_ready[1] !== 1'b0 || snk_valid[0] !== 1'b1 || io_in !== 19'h2AAAA) begin
      fails++; $display("FAIL pre_reset_state: ready1=%b valid0=%b io_in=%h want 0 1 2aaaa",
                        src_ready[1], snk_valid[0], io_in);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (src_ready !== 4'b0000 || snk_valid !== 4'b0000 || snk_data !== 112'b0 || io_in !== 19'h0
        || underrun !== 4'b0000 || overrun !== 4'b0000 || frame !== 1'b0) begin
      fails++; $display("FAIL async_reset: ready=%b valid=%b io_in=%h underrun=%b overrun=%b frame=%b want all 0",
                        src_ready, snk_valid, io_in, underrun, overrun, frame);
    end
    req_in = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_consume();
    test_underrun();
    test_multihot();
    test_overrun();
    test_back_to_back();
    test_frame();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/proc_io_ctrl.md
Name: proc_io_ctrl

Overview:
- I/O scheduler between the float processor wrapper and external streaming sources and sinks.
- Holds one sample per input port, each with a valid/ready handshake to its source.
- Presents the selected sample on the processor's io_in when the processor strobes req_in.
- Captures io_out into per-port output registers on out_en, drains them to sinks by valid/ready, and flags underrun/overrun.
- Emits a frame pulse once all masked output ports have been written.

Parameters:
- NUIOIN, 4, number of processor input ports
- NUIOOU, 4, number of processor output ports
- NBIN, 19, input sample width (signed integer, pre int2float)
- NBOUT, 28, output sample width (signed integer, post float2int)
- OUT_MASK, 4'b1111, output ports that must be written to complete a frame

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- src_data  in  NUIOIN*NBIN  packed source samples, port k at [k*NBIN +: NBIN]
- src_valid  in  NUIOIN  source k offers a sample
- src_ready  out  NUIOIN  slot k can accept (registered)
- req_in  in  NUIOIN  processor read strobe, one-hot from address decoder
- io_in  out  NBIN  sample to processor (combinational mux)
- io_out  in  NBOUT  processor output sample
- out_en  in  NUIOOU  processor write strobe, one-hot
- snk_data  out  NUIOOU*NBOUT  packed sink samples
- snk_valid  out  NUIOOU  sink register k holds unread data
- snk_ready  in  NUIOOU  sink k accepts
- underrun  out  NUIOIN  sticky: processor read an empty slot
- overrun  out  NUIOOU  sticky: processor overwrote an unread sink register
- clr_err  in  1  synchronous clear of sticky flags
- frame  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, immediate): all slot data, full[], snk_data, snk_valid, underrun, overrun, frame, written[] = 0; src_ready = 0.
- src_ready[k] is a register loaded each cycle with ~full_next[k]. It rises in the first clock after rst deasserts.

Input slot k, states EMPTY/FULL:
- EMPTY, src_valid & src_ready: data latched, go to FULL.
- FULL, req_in[k]: consumed, go to EMPTY.
- Because src_ready derives from full, load and consume never coincide on the same slot. Max rate is one sample per 2 cycles per port.
- req_in[k] while EMPTY: stay EMPTY, io_in returns the last held value (0 after reset), set underrun[k].
- io_in = data of the lowest-index asserted req_in bit; 0 when req_in == 0.
- Multi-hot req_in: only the lowest index is consumed; the others are ignored (no state change).

Output register k:
- out_en[k] at an edge: snk_data[k] <= io_out, snk_valid[k] <= 1. Every asserted bit captures.
- snk_valid[k] & snk_ready[k] without out_en[k]: snk_valid[k] <= 0.
- out_en[k] & snk_valid[k] & ~snk_ready[k]: data overwritten (newest wins), set overrun[k].
- out_en[k] & snk_valid[k] & snk_ready[k]: old word handed off, new word loaded, snk_valid stays 1, no overrun.

Frame:
- written[k] is set on out_en[k].
- When (written_next & OUT_MASK) == OUT_MASK, frame = 1 for one cycle and written[] clears, including the bit set in that cycle.
- A completing write and a write of the next frame in the same cycle are impossible with one-hot out_en.

Error flags:
- clr_err clears all sticky flags.
- A new error event in the same cycle as clr_err wins: the flag stays set.

Latency:
- src handshake to io_in available: 1 cycle.
- out_en to snk_valid: 1 cycle.

Decomposition:
- Package proc_io_pkg holds the default widths (NBIN, NBOUT, NUIOIN, NUIOOU) and the packed-slice helper function lane(k, width).
- One sub-module, io_in_slot: single-entry holding register with the full flag, registered ready and the underrun flag. It is instantiated NUIOIN times.
- Output registers and frame logic are inline.

Test Plan:
1. Reset, then src_valid[2]=1, src_data lane2=19'h12345. src_ready[2]=1 on the first cycle after reset and src_ready[2]=0 the cycle after the load. Then req_in=4'b0100 -> io_in=19'h12345 in that cycle; slot 2 EMPTY and src_ready[2]=1 the next cycle.
2. req_in=4'b0001 with slot 0 empty -> io_in=0, underrun=4'b0001. clr_err pulse -> underrun=0. clr_err coincident with a new empty read -> underrun stays 1.
3. out_en=4'b1000, io_out=28'h0ABCDEF, snk_ready=0 -> snk_valid[3]=1. Second out_en[3] with io_out=28'h1 -> snk_data lane3=28'h1, overrun[3]=1.
4. snk_valid[1]=1, snk_ready[1]=1 and out_en[1] in the same cycle -> new data loaded, snk_valid[1] stays 1, overrun[1]=0.
5. out_en sequence 1,2,4,8 on consecutive cycles -> frame pulses exactly once, the cycle after the 8. Repeating 1,1,2,4,8 -> again one pulse.
6. rst asserted while slot 1 is FULL and snk_valid[0]=1 -> all outputs 0 immediately, without waiting for a clock edge.
